// File: rtl/switch_event_axis_if.sv
// AXI4-Stream handshake bundle carrying debounced switch words.
interface switch_event_axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/switch_event_axis.sv
// Switch bank synchroniser + per-bit debouncer feeding an AXI4-Stream
// master through a small event FIFO (sample or change mode).
module switch_event_axis #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                  axis_aclk_i,
  input  logic                  axis_aresetn_i,
  input  logic [DATA_WIDTH-1:0] switches_i,
  input  logic                  mode_i,
  input  logic                  overflow_clr_i,
  switch_event_axis_if.master   m_axis,
  output logic                  overflow_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0]                 s1_q, s2_q;
  logic [DATA_WIDTH-1:0]                 deb_q, deb_d;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                      wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0]                      occ_q, occ_d;
  logic                                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]                 tdata_q, tdata_d;
  logic                                  ovf_q, ovf_d;

  logic pop_c, full_c, push_req_c, push_c, drop_c;

  // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Event generation and FIFO bookkeeping; head word is re-registered every cycle.
  always_comb begin
    pop_c  = tvalid_q && m_axis.tready;
    full_c = (occ_q == OCC_W'(FIFO_DEPTH));
    // Sample mode refills only when the FIFO is (or is about to be) empty.
    if (mode_i) begin
      push_req_c = (deb_d != deb_q);
    end else begin
      push_req_c = (occ_q == '0) || (pop_c && (occ_q == OCC_W'(1)));
    end
    push_c = push_req_c && (!full_c || pop_c);
    drop_c = push_req_c && full_c && !pop_c;

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push_c) begin
      mem_d[wr_q] = deb_d;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !push_c) begin
      occ_d = occ_q - OCC_W'(1);
    end

    tvalid_d = (occ_d != '0);
    tdata_d  = tvalid_d ? mem_d[rd_d] : '0;

    // A drop on the same edge as a clear keeps the flag set.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (overflow_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset discards FIFO contents immediately.
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= switches_i;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      occ_q    <= occ_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_switch_event_axis.sv
// Directed bench for switch_event_axis (DATA_WIDTH=8, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4).
module tb_switch_event_axis;

  logic       clk;
  logic       rst_n;
  logic [7:0] switches;
  logic       mode;
  logic       ovf_clr;
  logic       ovf;

  int n_cmp;
  int n_err;

  switch_event_axis_if #(.DATA_WIDTH(8)) axis ();

  switch_event_axis #(
    .DATA_WIDTH     (8),
    .DEBOUNCE_CYCLES(16),
    .FIFO_DEPTH     (4)
  ) dut (
    .axis_aclk_i   (clk),
    .axis_aresetn_i(rst_n),
    .switches_i    (switches),
    .mode_i        (mode),
    .overflow_clr_i(ovf_clr),
    .m_axis        (axis),
    .overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; switches = 8'h00; mode = 1'b1; ovf_clr = 1'b0; axis.tready = 1'b1;
    #12;
    n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
    n_cmp++; if (axis.tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata got=%h exp=00", axis.tdata); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if (axis.tvalid !== 1'b0 || axis.tdata !== 8'h00 || ovf !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d tvalid=%b tdata=%h ovf=%b exp 0/00/0", i, axis.tvalid, axis.tdata, ovf);
      end
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    axis.tready = 1'b1;
    switches = 8'hA5;
    // i-th iteration observes the state after edge k+i
    for (int i = 0; i <= 18; i++) begin
      tick();
      exp_v = (i == 17);
      n_cmp++;
      if (axis.tvalid !== exp_v) begin
        n_err++;
        $display("FAIL latency_tvalid edge=k+%0d got=%b exp=%b", i, axis.tvalid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (axis.tdata !== 8'hA5) begin n_err++; $display("FAIL latency_tdata got=%h exp=a5", axis.tdata); end
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL latency_extra_word cyc=%0d got tvalid=%b exp=0", i, axis.tvalid); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] seen [$];
    int glitch_words;
    axis.tready = 1'b1;
    switches = 8'h00;
    repeat (25) tick();
    // 10-cycle glitch must be filtered out
    glitch_words = 0;
    switches = 8'h01;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) switches = 8'h00;
      tick();
      if (axis.tvalid === 1'b1) glitch_words++;
    end
    n_cmp++;
    if (glitch_words != 0) begin n_err++; $display("FAIL glitch_filtered words=%0d exp=0", glitch_words); end
    // 16-cycle pulse is just long enough to register
    switches = 8'h01;
    for (int i = 0; i < 70; i++) begin
      if (i == 16) switches = 8'h00;
      tick();
      if (axis.tvalid === 1'b1) seen.push_back(axis.tdata);
    end
    n_cmp++;
    if (seen.size() != 2) begin
      n_err++; $display("FAIL pulse_word_count got=%0d exp=2", seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== 8'h01 || seen[1] !== 8'h00) begin
        n_err++; $display("FAIL pulse_words got=%h,%h exp=01,00", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals[0] = 8'h01; vals[1] = 8'h03; vals[2] = 8'h07; vals[3] = 8'h0F; vals[4] = 8'h1F;
    axis.tready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      switches = vals[j];
      repeat (20) tick();
      n_cmp++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h01) begin
        n_err++; $display("FAIL ovf_head_stable chg=%0d tvalid=%b tdata=%h exp 1/01", j, axis.tvalid, axis.tdata);
      end
      n_cmp++;
      if (ovf !== (j == 4)) begin
        n_err++; $display("FAIL ovf_flag chg=%0d got=%b exp=%b", j, ovf, (j == 4));
      end
    end
    axis.tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== vals[j]) begin
        n_err++; $display("FAIL ovf_drain idx=%0d tvalid=%b tdata=%h exp 1/%h", j, axis.tvalid, axis.tdata, vals[j]);
      end
      tick();
    end
    n_cmp++;
    if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL ovf_drained tvalid=%b exp=0", axis.tvalid); end
    n_cmp++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_sample_mode();
    mode = 1'b0;
    axis.tready = 1'b1;
    switches = 8'h3C;
    repeat (30) tick();
    for (int i = 0; i < 20; i++) begin
      axis.tready = (i % 2 == 0);
      tick();
      n_cmp++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h3C) begin
        n_err++; $display("FAIL sample_word cyc=%0d tvalid=%b tdata=%h exp 1/3c", i, axis.tvalid, axis.tdata);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL sample_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_midstream();
    mode = 1'b1;
    axis.tready = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL mid_predrain tvalid=%b exp=0", axis.tvalid); end
    axis.tready = 1'b0;
    switches = 8'h3D;
    repeat (20) tick();
    switches = 8'h3F;
    repeat (20) tick();
    n_cmp++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h3D) begin
      n_err++; $display("FAIL mid_two_words tvalid=%b tdata=%h exp 1/3d", axis.tvalid, axis.tdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 8'h00 || ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_async_reset tvalid=%b tdata=%h ovf=%b exp 0/00/0", axis.tvalid, axis.tdata, ovf);
    end
    switches = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    axis.tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL mid_stale_word cyc=%0d tvalid=%b tdata=%h exp 0", i, axis.tvalid, axis.tdata); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_overflow();
    test_sample_mode();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
